// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALRADR,
    S_JALR, S_LUI, S_TRAP
  } state_t;

  localparam state_t RESET_STATE = S_FETCH;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

  // Reserved funct3 encodings 010/011 are treated as not taken.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic lt, input logic ltu);
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 to an ALU operation; funct7b5 only selects SUB for R-type.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output alu_op_t    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: sequences each instruction and drives datapath selects/enables.
//   state      | meaning
//   FETCH      | read instr, PC <= PC+4
//   DECODE     | alu_out <= old_pc+imm, dispatch on opcode
//   MEMADR     | alu_out <= rs1+imm
//   MEMREAD    | read data memory at alu_out
//   MEMWB      | rd <= mem data
//   MEMWRITE   | write data memory at alu_out
//   EXECUTER   | rs1 op rs2
//   EXECUTEI   | rs1 op imm
//   ALUWB      | rd <= alu_out
//   BRANCH     | compare rs1/rs2, PC <= target if taken
//   JAL/JALR   | PC <= target, alu_out <= old_pc+4
//   JALRADR    | alu_out <= rs1+imm
//   LUI        | rd <= imm
//   TRAP       | unknown opcode, parked until reset
module mc_control_fsm
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       reg_write,
  output logic       instr_retire,
  output logic       illegal
);

  state_t  state_q, state_d;
  logic    illegal_q, illegal_d;
  alu_op_t dec_op;

  alu_decoder u_alu_decoder (
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .is_rtype (state_q == S_EXECUTER),
    .alu_op   (dec_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_FOUR;
    alu_ctrl     = ALU_ADD;
    reg_write    = 1'b0;
    instr_retire = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        result_src = RES_ALU;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALRADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = RES_MEM;
        reg_write    = 1'b1;
        instr_retire = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src      = 1'b1;
        mem_write    = 1'b1;
        instr_retire = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_ctrl  = dec_op;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = dec_op;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write    = 1'b1;
        instr_retire = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        alu_ctrl     = ALU_SUB;
        pc_write     = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
        instr_retire = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL, S_JALR: begin
        alu_src_a = SRC_A_OLDPC;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALRADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = S_JALR;
      end
      S_LUI: begin
        result_src   = RES_IMM;
        reg_write    = 1'b1;
        instr_retire = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // A reset caught mid-instruction must not let the aborted state write anything.
    if (reset && (state_q != S_FETCH)) begin
      pc_write     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      instr_retire = 1'b0;
    end

    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle.
module tb_mc_control_fsm;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd7, SRA = 4'd9;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, alu_zero, alu_lt, alu_ltu;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_ctrl;

  int checks = 0;
  int errors = 0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .reg_write(reg_write), .instr_retire(instr_retire),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pc_write, mem_write, ir_write, reg_write, instr_retire}
  function automatic logic [4:0] en();
    return {pc_write, mem_write, ir_write, reg_write, instr_retire};
  endfunction

  task automatic chk_fetch(input string tag);
    chk({tag, "_en"}, en(), 5'b10100);
    chk({tag, "_sel"}, {adr_src, alu_src_a, alu_src_b, alu_ctrl, result_src},
        {1'b0, 2'b00, 2'b10, ADD, 2'b10});
  endtask

  task automatic chk_decode(input string tag);
    chk({tag, "_en"}, en(), 5'b00000);
    chk({tag, "_sel"}, {alu_src_a, alu_src_b, alu_ctrl}, {2'b01, 2'b01, ADD});
  endtask

  initial begin
    reset = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;

    // Reset for two edges; state sits in FETCH with illegal clear.
    tick();
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_fetch_sel", {alu_src_a, alu_src_b, result_src}, {2'b00, 2'b10, 2'b10});
    tick();
    reset = 1'b0;
    #1;

    // R-type SUB: FETCH, DECODE, EXECUTER, ALUWB, FETCH.
    chk_fetch("r_c1");
    tick(); chk_decode("r_c2");
    tick();
    chk("r_exec_ctrl", alu_ctrl, SUB);
    chk("r_exec_sel", {alu_src_a, alu_src_b, en()}, {2'b10, 2'b00, 5'b00000});
    tick();
    chk("r_wb", {en(), result_src}, {5'b00011, 2'b00});
    tick(); chk_fetch("r_c5");

    // Load: 5 cycles, reg_write only in MEMWB.
    opcode = 7'b0000011;
    tick(); chk_decode("ld_c2");
    tick();
    chk("ld_memadr", {en(), alu_src_a, alu_src_b, alu_ctrl}, {5'b00000, 2'b10, 2'b01, ADD});
    tick();
    chk("ld_memread", {en(), adr_src, result_src}, {5'b00000, 1'b1, 2'b00});
    tick();
    chk("ld_memwb", {en(), result_src}, {5'b00011, 2'b01});
    tick(); chk_fetch("ld_c6");

    // BEQ taken with zero=1, then other conditions probed in the same BRANCH cycle.
    opcode = 7'b1100011; funct3 = 3'b000; alu_zero = 1'b1;
    tick(); chk_decode("beq_c2");
    tick();
    chk("beq_taken", {en(), alu_ctrl, result_src, alu_src_a, alu_src_b},
        {5'b10001, SUB, 2'b00, 2'b10, 2'b00});
    funct3 = 3'b001; #1;
    chk("bne_zero_nt", en(), 5'b00001);
    funct3 = 3'b100; alu_lt = 1'b1; #1;
    chk("blt_taken", pc_write, 1'b1);
    funct3 = 3'b101; #1;
    chk("bge_lt_nt", pc_write, 1'b0);
    funct3 = 3'b111; alu_ltu = 1'b0; #1;
    chk("bgeu_taken", pc_write, 1'b1);
    funct3 = 3'b010; alu_zero = 1'b1; alu_lt = 1'b1; alu_ltu = 1'b1; #1;
    chk("b010_nt", pc_write, 1'b0);
    tick(); chk_fetch("beq_c4");

    // BNE with zero=1: full 3-cycle run, not taken.
    funct3 = 3'b001; alu_zero = 1'b1; alu_lt = 1'b0; alu_ltu = 1'b0;
    tick(); chk_decode("bne_c2");
    tick(); chk("bne_branch", en(), 5'b00001);
    tick(); chk_fetch("bne_c4");

    // I-type: ADDI never becomes SUB; SRAI and SLLI decode in EXECUTEI.
    opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); chk_decode("addi_c2");
    tick();
    chk("addi_ctrl", {alu_ctrl, alu_src_a, alu_src_b}, {ADD, 2'b10, 2'b01});
    funct3 = 3'b101; #1;
    chk("srai_ctrl", alu_ctrl, SRA);
    funct3 = 3'b001; #1;
    chk("slli_ctrl", alu_ctrl, SLL);
    tick(); chk("addi_wb", en(), 5'b00011);
    tick(); chk_fetch("addi_c5");

    // LUI: 3 cycles, writes the immediate.
    opcode = 7'b0110111;
    tick(); chk_decode("lui_c2");
    tick(); chk("lui_wb", {en(), result_src}, {5'b00011, 2'b11});
    tick(); chk_fetch("lui_c4");

    // JAL: 4 cycles.
    opcode = 7'b1101111;
    tick(); chk_decode("jal_c2");
    tick();
    chk("jal_jump", {en(), result_src, alu_src_a, alu_src_b, alu_ctrl},
        {5'b10000, 2'b00, 2'b01, 2'b10, ADD});
    tick(); chk("jal_wb", en(), 5'b00011);
    tick(); chk_fetch("jal_c5");

    // JALR: 5 cycles.
    opcode = 7'b1100111;
    tick(); chk_decode("jalr_c2");
    tick(); chk("jalr_adr", {en(), alu_src_a, alu_src_b}, {5'b00000, 2'b10, 2'b01});
    tick(); chk("jalr_jump", {en(), alu_src_a, alu_src_b}, {5'b10000, 2'b01, 2'b10});
    tick(); chk("jalr_wb", en(), 5'b00011);
    tick(); chk_fetch("jalr_c6");

    // Unknown opcode traps and stays parked with everything disabled.
    opcode = 7'b0000000;
    tick(); chk_decode("trap_c2");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("trap_c%0d", i), {illegal, en()}, {1'b1, 5'b00000});
    end
    reset = 1'b1;
    tick();
    chk("trap_rst_illegal", illegal, 1'b0);
    reset = 1'b0; #1;
    chk_fetch("trap_rst_fetch");

    // Store, aborted by reset while in MEMWRITE.
    opcode = 7'b0100011;
    tick(); chk_decode("st_c2");
    tick(); chk("st_memadr", en(), 5'b00000);
    tick(); chk("st_memwrite", {en(), adr_src}, {5'b01001, 1'b1});
    reset = 1'b1; #1;
    chk("st_rst_same_cycle", en(), 5'b00000);
    tick();
    chk("st_rst_next_mem_write", mem_write, 1'b0);
    reset = 1'b0; #1;
    chk_fetch("st_rst_fetch");
    tick(); chk_decode("st_after_rst_decode");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
